// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
//   ADDR_LEN / INSTR_LEN : default address and instruction widths
//   PC_STEP              : byte distance to the sequential next instruction
//   if_state_e           : fetch FSM state encoding (IDLE/REQ/WAIT/DRAIN)
package ifetch_unit_pkg;

  localparam int ADDR_LEN  = 32;
  localparam int INSTR_LEN = 32;
  localparam int PC_STEP   = 4;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_REQ   = 2'd1,
    IF_WAIT  = 2'd2,
    IF_DRAIN = 2'd3
  } if_state_e;

endpackage

// File: rtl/ifetch_unit.sv
// Fetch stage of the multi-cycle CPU, sitting right after the PC register.
// A start pulse samples pc_in, performs one req/gnt + rvalid read on the
// instruction memory, loads the returned word into the IR and hands PC+4
// back to the PC register together with its write enable.
// A flush cancels the fetch; a response already owed by the memory is
// absorbed in DRAIN and dropped.
//
// Ports:
//   clk, rst                  clock (rising edge), async reset active-low
//   start, flush              fetch request / redirect cancel
//   pc_in                     current PC
//   imem_req/addr/gnt         memory request channel
//   imem_rvalid/rdata         memory response channel
//   ir_out                    instruction register
//   done, pc_we               1-cycle pulses when the IR is updated
//   pc_next                   fetch address + 4 (wraps)
//   busy                      FSM not idle
//   fetch_err                 1-cycle pulse on a misaligned PC
//   dbg_state                 raw FSM state, for debug/checkers
//
// Handshake: the request is presented while imem_req=1 with imem_addr
// stable and is accepted in the cycle imem_gnt=1. Each accepted request
// returns exactly one imem_rvalid cycle, at any later cycle.
//
// Build option: define IFETCH_ALIGN_CHK_EN to reject PCs with pc_in[1:0]!=0
// (fetch_err pulse, no memory access). Without it fetch_err is tied low.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter int ADDR_W  = ADDR_LEN,
  parameter int INSTR_W = INSTR_LEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ir_out,
  output logic               done,
  output logic               pc_we,
  output logic [ADDR_W-1:0]  pc_next,
  output logic               busy,
  output logic               fetch_err,
  output logic [1:0]         dbg_state
);

  if_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  pc_next_q, pc_next_d;
  logic               done_q, done_d;
  logic               pc_we_q, pc_we_d;
  logic               err_q, err_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    ir_d      = ir_q;
    pc_next_d = pc_next_q;
    done_d    = 1'b0;
    pc_we_d   = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IF_IDLE: begin
        if (start && !flush) begin
`ifdef IFETCH_ALIGN_CHK_EN
          if (pc_in[1:0] != 2'b00) begin
            err_d = 1'b1;
          end else begin
            addr_d  = pc_in;
            state_d = IF_REQ;
          end
`else
          addr_d  = pc_in;
          state_d = IF_REQ;
`endif
        end
      end
      IF_REQ: begin
        // A grant in the flush cycle still commits the memory to a response,
        // so it must be drained rather than abandoned.
        if (imem_gnt) begin
          state_d = flush ? IF_DRAIN : IF_WAIT;
        end else if (flush) begin
          state_d = IF_IDLE;
        end
      end
      IF_WAIT: begin
        if (imem_rvalid) begin
          state_d = IF_IDLE;
          if (!flush) begin
            ir_d      = imem_rdata;
            done_d    = 1'b1;
            pc_we_d   = 1'b1;
            pc_next_d = addr_q + ADDR_W'(PC_STEP);
          end
        end else if (flush) begin
          state_d = IF_DRAIN;
        end
      end
      IF_DRAIN: begin
        // Flush is irrelevant here: the data is discarded anyway.
        if (imem_rvalid) begin
          state_d = IF_IDLE;
        end
      end
      default: state_d = IF_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IF_IDLE;
      addr_q    <= '0;
      ir_q      <= '0;
      pc_next_q <= '0;
      done_q    <= 1'b0;
      pc_we_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      ir_q      <= ir_d;
      pc_next_q <= pc_next_d;
      done_q    <= done_d;
      pc_we_q   <= pc_we_d;
      err_q     <= err_d;
    end
  end

  assign imem_req  = (state_q == IF_REQ);
  assign busy      = (state_q != IF_IDLE);
  assign imem_addr = addr_q;
  assign ir_out    = ir_q;
  assign pc_next   = pc_next_q;
  assign done      = done_q;
  assign pc_we     = pc_we_q;
  assign fetch_err = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit. The memory side is driven by tasks;
// each fetch is described as a transaction (PC, data, grant delay, response
// delay, flush point) and its outcome is predicted from the fetch rules:
// an unflushed fetch updates IR with the data and pc_next with PC+4 and
// pulses done/pc_we once; any flushed fetch leaves IR and pc_next alone.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [31:0] pc_in;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] ir_out;
  logic        done;
  logic        pc_we;
  logic [31:0] pc_next;
  logic        busy;
  logic        fetch_err;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // Architectural expectation of the IR and PC-next registers.
  logic [31:0] exp_ir;
  logic [31:0] exp_pc;

  // Flush points of a transaction.
  localparam int M_NONE     = 0;
  localparam int M_WITHDRAW = 1;  // flush in REQ, no grant
  localparam int M_WITH_GNT = 2;  // flush together with grant
  localparam int M_IN_WAIT  = 3;  // flush while waiting for data
  localparam int M_WITH_RV  = 4;  // flush together with rvalid

  ifetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .flush       (flush),
    .pc_in       (pc_in),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .ir_out      (ir_out),
    .done        (done),
    .pc_we       (pc_we),
    .pc_next     (pc_next),
    .busy        (busy),
    .fetch_err   (fetch_err),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_idle();
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_req", {31'd0, imem_req}, 32'd0);
    check("idle_done", {31'd0, done}, 32'd0);
    check("idle_pcwe", {31'd0, pc_we}, 32'd0);
    check("idle_err", {31'd0, fetch_err}, 32'd0);
    check("idle_ir", ir_out, exp_ir);
    check("idle_pcnext", pc_next, exp_pc);
  endtask

  // Idle cycles; start may be offered together with flush, which must not fetch.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'($urandom_range(0, 1));
      flush = start;
      pc_in = $urandom;
      @(negedge clk);
      check_idle();
    end
    start = 1'b0;
    flush = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data,
                          input int gd, input int rd, input int mode);
    int rdl;
    rdl   = (mode == M_IN_WAIT && rd == 0) ? 1 : rd;
    pc_in = pc;
    start = 1'b1;
    flush = 1'b0;
    @(negedge clk);
    start = 1'b0;
    pc_in = $urandom;  // the address must come from the sampled PC
    check("req_issue", {31'd0, imem_req}, 32'd1);
    check("req_addr", imem_addr, pc);
    check("req_busy", {31'd0, busy}, 32'd1);
    check("req_done_low", {31'd0, done}, 32'd0);
    check("req_pcwe_low", {31'd0, pc_we}, 32'd0);

    for (int i = 0; i < gd; i++) begin
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("req_hold", {31'd0, imem_req}, 32'd1);
      check("addr_hold", imem_addr, pc);
      check("busy_req", {31'd0, busy}, 32'd1);
    end

    start = 1'($urandom_range(0, 1));
    if (mode == M_WITHDRAW) begin
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      start = 1'b0;
      check("wd_req_drop", {31'd0, imem_req}, 32'd0);
      check("wd_idle", {31'd0, busy}, 32'd0);
      check("wd_done", {31'd0, done}, 32'd0);
      check("wd_ir", ir_out, exp_ir);
      return;
    end

    imem_gnt = 1'b1;
    flush    = (mode == M_WITH_GNT);
    @(negedge clk);
    imem_gnt = 1'b0;
    flush    = 1'b0;
    check("gnt_req_drop", {31'd0, imem_req}, 32'd0);
    check("gnt_busy", {31'd0, busy}, 32'd1);

    for (int i = 0; i < rdl; i++) begin
      start = 1'($urandom_range(0, 1));
      if (mode == M_IN_WAIT && i == 0) flush = 1'b1;
      else if (mode == M_WITH_GNT || mode == M_IN_WAIT) flush = 1'($urandom_range(0, 1));
      else flush = 1'b0;
      @(negedge clk);
      flush = 1'b0;
      check("wait_busy", {31'd0, busy}, 32'd1);
      check("wait_req", {31'd0, imem_req}, 32'd0);
      check("wait_done", {31'd0, done}, 32'd0);
    end

    imem_rvalid = 1'b1;
    imem_rdata  = data;
    start       = 1'($urandom_range(0, 1));
    if (mode == M_WITH_RV) flush = 1'b1;
    else if (mode == M_WITH_GNT || mode == M_IN_WAIT) flush = 1'($urandom_range(0, 1));
    else flush = 1'b0;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    flush       = 1'b0;
    start       = 1'b0;

    if (mode == M_NONE) begin
      exp_ir = data;
      exp_pc = pc + 32'd4;
      check("done_pulse", {31'd0, done}, 32'd1);
      check("pcwe_pulse", {31'd0, pc_we}, 32'd1);
    end else begin
      check("flushed_done", {31'd0, done}, 32'd0);
      check("flushed_pcwe", {31'd0, pc_we}, 32'd0);
    end
    check("resp_ir", ir_out, exp_ir);
    check("resp_pcnext", pc_next, exp_pc);
    check("resp_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    flush       = 1'b0;
    pc_in       = 32'd0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    exp_ir      = 32'd0;
    exp_pc      = 32'd0;
    #1 rst = 1'b0;
    #1;
    check("rst_ir", ir_out, 32'd0);
    check("rst_pcnext", pc_next, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_flags", {27'd0, done, pc_we, fetch_err, imem_req, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle_cycles(2);

    // Zero-wait fetch, then wait states.
    do_fetch(32'h0000_0100, 32'h00A0_0093, 0, 0, M_NONE);
    idle_cycles(1);
    do_fetch(32'h0000_0140, 32'h1111_2222, 3, 2, M_NONE);
    idle_cycles(1);

    // Flush in WAIT drains the response, then a clean fetch.
    do_fetch(32'h0000_0180, 32'hDEAD_BEEF, 0, 2, M_IN_WAIT);
    idle_cycles(1);
    do_fetch(32'h0000_0200, 32'h1234_5678, 0, 0, M_NONE);
    idle_cycles(1);

    // Withdraw in REQ, and flush coincident with grant.
    do_fetch(32'h0000_0240, 32'hAAAA_AAAA, 1, 0, M_WITHDRAW);
    idle_cycles(2);
    do_fetch(32'h0000_0280, 32'hBBBB_BBBB, 0, 1, M_WITH_GNT);
    idle_cycles(1);
    do_fetch(32'h0000_02C0, 32'hCCCC_CCCC, 1, 1, M_WITH_RV);
    idle_cycles(1);

    // Wrap, followed back-to-back by a start issued in the done cycle.
    do_fetch(32'hFFFF_FFFC, 32'h0000_0013, 0, 0, M_NONE);
    do_fetch(32'h0000_0400, 32'h0040_0113, 0, 0, M_NONE);
    idle_cycles(1);

    // Misaligned PC.
`ifdef IFETCH_ALIGN_CHK_EN
    pc_in = 32'h0000_0102;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("align_err", {31'd0, fetch_err}, 32'd1);
    check("align_noreq", {31'd0, imem_req}, 32'd0);
    check("align_busy", {31'd0, busy}, 32'd0);
    check("align_pcwe", {31'd0, pc_we}, 32'd0);
    check("align_ir", ir_out, exp_ir);
    check("align_pcnext", pc_next, exp_pc);
    @(negedge clk);
    check("align_err_pulse", {31'd0, fetch_err}, 32'd0);
    check("align_noreq2", {31'd0, imem_req}, 32'd0);
`else
    do_fetch(32'h0000_0102, 32'h5555_AAAA, 0, 1, M_NONE);
    check("noalign_err", {31'd0, fetch_err}, 32'd0);
`endif
    idle_cycles(1);

    // Asynchronous reset in the middle of WAIT.
    pc_in = 32'h0000_0300;
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_ir", ir_out, 32'd0);
    check("arst_pcnext", pc_next, 32'd0);
    check("arst_addr", imem_addr, 32'd0);
    check("arst_flags", {27'd0, done, pc_we, fetch_err, imem_req, busy}, 32'd0);
    exp_ir = 32'd0;
    exp_pc = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    idle_cycles(2);

    // Randomized transactions.
    for (int n = 0; n < 60; n++) begin
      do_fetch($urandom & 32'hFFFF_FFFC, $urandom, $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 4));
      idle_cycles($urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
